transpose_scheduler: RTL
========================

# transpose_scheduler

Sequences multi-pass jobs through the single-cycle matrix transpose unit in the HE datapath. Accepts one job descriptor at a time (pass count, per-pass transpose/bypass mask, beats per pass), streams source beats into the transpose unit with the correct `ctrl` level, counts returned beats, and clears the unit between passes. Sits between the NTT stage buffers and the transpose unit and owns that unit's `ctrl`, `rst` and `in_val` inputs.

## Interface
- `MAX_PASSES`, 4: passes per job, ≥1.
- `CNT_W`, 16: width of the beat counters and `job_beats`.
- `PASS_W`, 3: width of `job_passes`, ≥ clog2(MAX_PASSES+1).
- `clk`  in  1  clock, all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  job descriptor valid.
- `job_ready`  out  1  scheduler can accept a job.
- `job_passes`  in  PASS_W  number of passes.
- `job_mask`  in  MAX_PASSES  bit p=1: pass p transposes; 0: pass p bypasses.
- `job_beats`  in  CNT_W  beats per pass.
- `src_valid`  in  1  source beat available.
- `src_ready`  out  1  scheduler takes the source beat.
- `mt_in_val`  out  1  to transpose unit `in_val`.
- `mt_ctrl`  out  1  to transpose unit `ctrl`.
- `mt_clr`  out  1  to transpose unit `rst` (synchronous clear).
- `mt_out_val`  in  1  from transpose unit `out_val`.
- `pass_idx`  out  PASS_W  current pass index.
- `busy`  out  1  high in any state other than IDLE.
- `job_done`  out  1  one-cycle pulse at job end.
- `job_err`  out  1  qualifies `job_done`: the job was degenerate.
- `perf_busy_cyc`  out  32  busy-cycle counter (see Configuration).
- `perf_stall_cyc`  out  32  ISSUE cycles with `src_valid`=0.

## Operation
- States: IDLE, ISSUE, DRAIN, CLEAR, DONE.
- IDLE: `job_ready`=1. On `job_valid`: latch mask and beats, and latch passes clamped to MAX_PASSES. Zero passes or zero beats → DONE with the error flag set. Otherwise → ISSUE with `pass_idx`=0 and both counters cleared.
- ISSUE: `src_ready`=1. `mt_in_val` = `src_valid`&`src_ready` (combinational). Each handshake increments `issue_cnt`. The handshake that brings `issue_cnt` to `beats` moves to DRAIN.
- `mt_ctrl` = `mask[pass_idx]` in ISSUE and DRAIN; 0 in every other state. The transpose unit gives `ctrl` priority over its `rst`, so `mt_ctrl` must be 0 during CLEAR.
- `ret_cnt` increments on `mt_out_val` in ISSUE and DRAIN only. `mt_out_val` is ignored in IDLE, CLEAR and DONE.
- DRAIN: when `ret_cnt` == `beats` (the increment counts this cycle), → CLEAR.
- CLEAR: `mt_clr`=1 for exactly one cycle; counters are cleared. If `pass_idx`+1 < passes, increment `pass_idx` → ISSUE; else → DONE.
- DONE: `job_done`=1 for one cycle, `job_err` = error flag, → IDLE. A new job is accepted in the following IDLE cycle at the earliest.
- Counters do not wrap: `beats` ≤ 2^CNT_W−1, so `issue_cnt` saturates at `beats`.

## Timing
- Reset values: state IDLE; `job_ready`=1. All other outputs 0: `src_ready`, `mt_*`, `pass_idx`, `busy`, `job_done`, `job_err`, `perf_*`. All counters 0.
- `rst_n` low mid-job aborts immediately, with no final `mt_clr`. The datapath must be reset with it.
- Job accept to first `src_ready`: 1 cycle.
- Transpose unit latency is 1. The last issue handshake at cycle t gives DRAIN at t+1, CLEAR at t+2 (when the final return arrives at t+1), and the next pass's ISSUE at t+3.
- Minimum job duration: passes×(beats+2)+2 cycles, from accept to the `job_done` cycle inclusive.
- All outputs except `mt_in_val` and `src_ready` are registered.

## Configuration
- `TSCHED_PERF_EN` defined: `perf_busy_cyc` increments every cycle `busy`=1. `perf_stall_cyc` increments every ISSUE cycle with `src_valid`=0. Both saturate at 2^32−1 and clear only on reset.
- `TSCHED_PERF_EN` undefined: no counter logic is built; both `perf_*` ports are tied to 0.

## Test plan
- Single pass, passes=1, mask=1, beats=4, `src_valid` always high → `mt_in_val` and `mt_ctrl`=1 for 4 cycles, one `mt_clr` pulse, `job_done`=1 with `job_err`=0 exactly 8 cycles after accept.
- Mixed passes=3, mask=3'b101, beats=2 → `mt_ctrl` is 1, 0, 1 per pass, with 3 `mt_clr` pulses and `mt_ctrl`=0 on each pulse.
- Stalls: beats=4, `src_valid` low for 3 ISSUE cycles → completion delayed 3 cycles; with `TSCHED_PERF_EN`, `perf_stall_cyc`=3.
- Degenerate: beats=0 → no `src_ready`, no `mt_*` activity; `job_done`=`job_err`=1 two cycles after accept. passes=7 with MAX_PASSES=4 → exactly 4 passes run.
- Spurious `mt_out_val` pulses in IDLE and CLEAR → no state change; `ret_cnt` unaffected.
- `rst_n` asserted in the middle of the second pass → outputs reach their reset values asynchronously; after release the next job runs normally from `pass_idx`=0.

Source files
------------

// File: rtl/transpose_scheduler.sv
// Multi-pass job sequencer for the single-cycle matrix transpose unit.
// Optional perf counters are built only when TSCHED_PERF_EN is defined.
module transpose_scheduler #(
  parameter int MAX_PASSES = 4,
  parameter int CNT_W      = 16,
  parameter int PASS_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [PASS_W-1:0]     job_passes,
  input  logic [MAX_PASSES-1:0] job_mask,
  input  logic [CNT_W-1:0]      job_beats,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic                  mt_in_val,
  output logic                  mt_ctrl,
  output logic                  mt_clr,
  input  logic                  mt_out_val,
  output logic [PASS_W-1:0]     pass_idx,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err,
  output logic [31:0]           perf_busy_cyc,
  output logic [31:0]           perf_stall_cyc
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CLEAR, S_DONE} state_t;

  localparam logic [PASS_W-1:0] MAX_P = PASS_W'(MAX_PASSES);

  state_t                state, state_n;
  logic [MAX_PASSES-1:0] mask_q, mask_n, mask_sh;
  logic [CNT_W-1:0]      beats_q, beats_n;
  logic [PASS_W-1:0]     passes_q, passes_n, pidx_n, passes_clamp;
  logic [CNT_W-1:0]      issue_cnt, issue_n, ret_cnt, ret_n, ret_nxt;
  logic                  err_q, err_n;
  logic                  hs, ret_inc, ctrl_n;

  assign src_ready    = (state == S_ISSUE);
  assign hs           = src_valid && (state == S_ISSUE);
  assign mt_in_val    = hs;
  assign passes_clamp = (job_passes > MAX_P) ? MAX_P : job_passes;
  assign ret_inc      = mt_out_val && (state == S_ISSUE || state == S_DRAIN) && (ret_cnt != beats_q);
  assign ret_nxt      = ret_cnt + CNT_W'(ret_inc);

  always_comb begin
    state_n  = state;
    mask_n   = mask_q;
    beats_n  = beats_q;
    passes_n = passes_q;
    pidx_n   = pass_idx;
    err_n    = err_q;
    issue_n  = issue_cnt;
    ret_n    = ret_nxt;
    case (state)
      S_IDLE: begin
        issue_n = '0;
        ret_n   = '0;
        if (job_valid) begin
          mask_n   = job_mask;
          beats_n  = job_beats;
          passes_n = passes_clamp;
          pidx_n   = '0;
          err_n    = (passes_clamp == '0) || (job_beats == '0);
          state_n  = err_n ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs && issue_cnt != beats_q) begin
          issue_n = issue_cnt + CNT_W'(1);
          if (issue_cnt == beats_q - CNT_W'(1)) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_nxt == beats_q) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        issue_n = '0;
        ret_n   = '0;
        if ({1'b0, pass_idx} + (PASS_W+1)'(1) < {1'b0, passes_q}) begin
          pidx_n  = pass_idx + PASS_W'(1);
          state_n = S_ISSUE;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs are derived from next-state values so they line up with the state they describe.
  assign mask_sh = mask_n >> pidx_n;
  assign ctrl_n  = (state_n == S_ISSUE || state_n == S_DRAIN) && mask_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mask_q    <= '0;
      beats_q   <= '0;
      passes_q  <= '0;
      pass_idx  <= '0;
      err_q     <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      job_ready <= 1'b1;
      busy      <= 1'b0;
      mt_ctrl   <= 1'b0;
      mt_clr    <= 1'b0;
      job_done  <= 1'b0;
      job_err   <= 1'b0;
    end else begin
      state     <= state_n;
      mask_q    <= mask_n;
      beats_q   <= beats_n;
      passes_q  <= passes_n;
      pass_idx  <= pidx_n;
      err_q     <= err_n;
      issue_cnt <= issue_n;
      ret_cnt   <= ret_n;
      job_ready <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
      mt_ctrl   <= ctrl_n;
      mt_clr    <= (state_n == S_CLEAR);
      job_done  <= (state_n == S_DONE);
      job_err   <= (state_n == S_DONE) && err_n;
    end
  end

`ifdef TSCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (state == S_ISSUE && !src_valid && perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`else
  assign perf_busy_cyc  = '0;
  assign perf_stall_cyc = '0;
`endif

endmodule
